// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues single outstanding imem reads, queues {pc, word} for decode.
// Latency: ack in cycle N -> instr_valid in N+1; sustains one instruction/cycle with same-cycle acks.
// Backpressure: instr_valid/instr_ready; requests pause when the queue has no free slot. Option macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_instr_d [QDEPTH];
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [31:0]   q_pc_d    [QDEPTH];

  logic          push, pop, space;
  logic [CW:0]   level;
  logic [31:0]   target;
  logic          trap;   // redirect that must stop fetching
  logic          halt;   // fetching is parked until a clean redirect

  // Low address bits never reach the PC; a word address is always produced.
  assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign trap     = redirect && (redirect_pc[1:0] != 2'b00);
  assign halt     = misalign_q;
  assign misalign = misalign_q;

  // Sticky flag: only a redirect changes it, aligned clears, misaligned sets.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  // Misalign flag register.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  assign trap     = 1'b0;
  assign halt     = 1'b0;
  assign misalign = 1'b0;
`endif

  assign imem_req    = (state_q != S_IDLE);
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = q_instr_q[head_q];
  assign instr_pc    = q_pc_q[head_q];

  // A redirect kills both queue movements in its cycle.
  assign pop   = instr_valid && instr_ready && !redirect;
  assign push  = (state_q == S_FETCH) && imem_ack && !redirect;
  assign level = {1'b0, count_q} - (CW+1)'(pop) + (CW+1)'(push);
  assign space = level < (CW+1)'(QDEPTH);

  // Queue bookkeeping plus fetch FSM next-state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    q_instr_d = q_instr_q;
    q_pc_d    = q_pc_q;

    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        q_instr_d[tail_q] = imem_rdata;
        q_pc_d[tail_q]    = pc_q;
        tail_d            = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = level[CW-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = target;
        end else if (space && !halt) begin
          state_d = S_FETCH;
          addr_d  = pc_q;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
          if (trap)          state_d = S_IDLE;
          else if (imem_ack) addr_d  = target;   // stale data dropped, go straight to target
          else               state_d = S_FLUSH;  // wait out the in-flight read
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (space) addr_d  = pc_q + 32'd4;
          else       state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (redirect) pc_d = target;
        if (trap) begin
          state_d = S_IDLE;
        end else if (imem_ack) begin
          state_d = S_FETCH;
          addr_d  = redirect ? target : pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC, address and queue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      q_instr_q <= q_instr_d;
      q_pc_q    <= q_pc_d;
    end
  end

endmodule
